// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq
// Purpose  : Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WB
//            with branch redirect, misaligned-target halt and retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o,
  output logic [2:0]  stage_o,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  input  logic        mem_busy_i,
  output logic        wb_en_o,
  output logic        fault_o,
  output logic [31:0] retired_o
);

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd7
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_target;
  logic [31:0] r_retired;
  logic        r_redir;
  logic        r_fault;
  logic        r_wb_en;
  logic        w_misaligned;

  assign w_misaligned = redirect_i && (target_i[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= NOP_INSN;
      r_target  <= 32'h0000_0000;
      r_retired <= 32'h0000_0000;
      r_redir   <= 1'b0;
      r_fault   <= 1'b0;
      r_wb_en   <= 1'b0;
    end else begin
      r_wb_en <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (imem_ack_i) begin
            r_ir    <= imem_data_i;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: r_state <= ST_EXECUTE;
        ST_EXECUTE: begin
          // A misaligned taken target freezes the core without retiring.
          if (w_misaligned) begin
            r_fault <= 1'b1;
            r_state <= ST_HALT;
          end else begin
            if (redirect_i) begin
              r_redir  <= 1'b1;
              r_target <= target_i;
            end
            r_state <= ST_MEM;
          end
        end
        ST_MEM: begin
          if (!mem_busy_i) begin
            r_wb_en <= 1'b1;
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          r_pc      <= r_redir ? r_target : r_pc + 32'd4;
          r_redir   <= 1'b0;
          r_retired <= r_retired + 32'd1;
          r_state   <= ST_FETCH;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_HALT;
      endcase
    end
  end

  // Request is gated by reset so it stays low for the whole reset window.
  assign imem_req_o  = (r_state == ST_FETCH) && !reset;
  assign imem_addr_o = r_pc;
  assign pc_o        = r_pc;
  assign ir_o        = r_ir;
  assign stage_o     = r_state;
  assign wb_en_o     = r_wb_en;
  assign fault_o     = r_fault;
  assign retired_o   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_seq
// Purpose  : Self-checking bench for fetch_seq with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_seq;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'h0;
  logic [31:0] ir_o;
  logic [31:0] pc_o;
  logic [2:0]  stage_o;
  logic        redirect_i = 1'b0;
  logic [31:0] target_i = 32'h0;
  logic        mem_busy_i = 1'b0;
  logic        wb_en_o;
  logic        fault_o;
  logic [31:0] retired_o;

  fetch_seq #(.RESET_PC(C_RESET_PC), .NOP_INSN(C_NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .ir_o(ir_o), .pc_o(pc_o), .stage_o(stage_o),
    .redirect_i(redirect_i), .target_i(target_i), .mem_busy_i(mem_busy_i),
    .wb_en_o(wb_en_o), .fault_o(fault_o), .retired_o(retired_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural view of the sequencer, advanced once per instruction.
  logic [31:0] m_pc, m_ir, m_ret;
  logic        m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic [2:0] st);
    #1;
    chk("stage",     {29'b0, stage_o},    {29'b0, st});
    chk("imem_req",  {31'b0, imem_req_o}, {31'b0, (st == 3'd0) && !reset});
    chk("imem_addr", imem_addr_o, m_pc);
    chk("pc",        pc_o, m_pc);
    chk("ir",        ir_o, m_ir);
    chk("retired",   retired_o, m_ret);
    chk("wb_en",     {31'b0, wb_en_o}, {31'b0, st == 3'd4});
    chk("fault",     {31'b0, fault_o}, {31'b0, m_fault});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic noise();
    imem_ack_i  = 1'($urandom_range(0, 1));
    imem_data_i = $urandom;
    redirect_i  = 1'($urandom_range(0, 1));
    target_i    = $urandom;
    mem_busy_i  = 1'($urandom_range(0, 1));
  endtask

  task automatic model_reset();
    m_pc = C_RESET_PC; m_ir = C_NOP; m_ret = 32'h0; m_fault = 1'b0;
  endtask

  // Assert reset over whatever inputs are already applied, hold, then release.
  task automatic reset_cycle();
    reset = 1'b1;
    tick();
    model_reset();
    check_all(3'd0);
    noise();
    tick();
    check_all(3'd0);
    reset = 1'b0;
  endtask

  // One instruction; returns 0 retired, 1 aborted by reset, 2 halted.
  task automatic run_insn(input int ack_dly, input logic [31:0] data, input logic redir,
                          input logic [31:0] tgt, input int stall, input logic spur,
                          input int abort_st, output int status);
    logic [1:0] low;
    status = 0;
    for (int i = 0; i <= ack_dly; i++) begin
      check_all(3'd0);
      noise();
      imem_ack_i = (i == ack_dly);
      if (i == ack_dly) imem_data_i = data;
      if (abort_st == 0 && i == ack_dly) begin reset_cycle(); status = 1; return; end
      tick();
    end
    m_ir = data;
    check_all(3'd1);
    noise();
    imem_ack_i = spur;
    if (abort_st == 1) begin reset_cycle(); status = 1; return; end
    tick();
    check_all(3'd2);
    noise();
    redirect_i = redir;
    target_i   = tgt;
    if (abort_st == 2) begin reset_cycle(); status = 1; return; end
    tick();
    low = tgt[1:0];
    if (redir && low != 2'b00) begin
      m_fault = 1'b1;
      for (int k = 0; k < 4; k++) begin
        check_all(3'd7);
        noise();
        tick();
      end
      status = 2;
      return;
    end
    for (int j = 0; j <= stall; j++) begin
      check_all(3'd3);
      noise();
      mem_busy_i = (j < stall);
      redirect_i = 1'b1;
      target_i   = $urandom & 32'hFFFF_FFFC;
      if (abort_st == 3 && j == stall) begin reset_cycle(); status = 1; return; end
      tick();
    end
    check_all(3'd4);
    noise();
    if (abort_st == 4) begin reset_cycle(); status = 1; return; end
    tick();
    m_pc  = redir ? tgt : m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
  endtask

  initial begin
    int st;
    model_reset();
    noise();
    tick();
    reset_cycle();

    // Straight-line first instruction after reset.
    run_insn(0, 32'h0050_0093, 1'b0, 32'h0, 0, 1'b0, -1, st);
    #1;
    chk("first_pc", pc_o, 32'd4);
    chk("first_retired", retired_o, 32'd1);
    chk("first_ir", ir_o, 32'h0050_0093);

    // Late ack with a spurious ack in DECODE.
    run_insn(3, $urandom, 1'b0, 32'h0, 0, 1'b1, -1, st);

    // Taken branch; MEM-cycle redirects must be ignored.
    run_insn(0, $urandom, 1'b1, 32'h100, 1, 1'b0, -1, st);
    #1;
    chk("branch_pc", imem_addr_o, 32'h100);

    // PC wrap from the top of the address space with a 2-cycle stall.
    run_insn(1, $urandom, 1'b1, 32'hFFFF_FFFC, 0, 1'b0, -1, st);
    run_insn(0, $urandom, 1'b0, 32'h0, 2, 1'b0, -1, st);
    #1;
    chk("wrap_pc", pc_o, 32'h0);

    // Randomised traffic, including occasional mid-instruction resets.
    for (int n = 0; n < 40; n++) begin
      int ab;
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_insn(int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
               $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), ab, st);
    end

    // Reset coincident with the MEM stall release.
    run_insn(0, $urandom, 1'b0, 32'h0, 2, 1'b0, 3, st);
    #1;
    chk("memrst_retired", retired_o, 32'h0);
    chk("memrst_pc", pc_o, C_RESET_PC);
    chk("memrst_status", st, 1);

    // Misaligned target: absorbing HALT until reset.
    run_insn(0, $urandom, 1'b0, 32'h0, 0, 1'b0, -1, st);
    run_insn(0, $urandom, 1'b1, 32'h102, 0, 1'b0, -1, st);
    #1;
    chk("halt_status", st, 2);
    chk("halt_fault", {31'b0, fault_o}, 32'd1);
    chk("halt_retired", retired_o, 32'd1);
    reset_cycle();
    run_insn(0, $urandom, 1'b0, 32'h0, 0, 1'b0, -1, st);
    check_all(3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSN, default 32'h0000_0013, ir_o value on reset (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req_o  output  1  instruction memory read request.
REQ-006 imem_addr_o  output  32  read address, equal to pc_o.
REQ-007 imem_ack_i  input  1  read data valid this cycle.
REQ-008 imem_data_i  input  32  read data, qualified by imem_ack_i.
REQ-009 ir_o  output  32  latched instruction word for the decode stage.
REQ-010 pc_o  output  32  address of the instruction in ir_o.
REQ-011 stage_o  output  3  current stage: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEM, 4 WB, 7 HALT.
REQ-012 redirect_i  input  1  branch/jump taken, from execute.
REQ-013 target_i  input  32  redirect destination.
REQ-014 mem_busy_i  input  1  data-memory stall request.
REQ-015 wb_en_o  output  1  register-file write strobe to decode (drives wd_q_i).
REQ-016 fault_o  output  1  misaligned-target fault, sticky.
REQ-017 retired_o  output  32  count of completed instructions.

Function
REQ-018 Stage sequencing SHALL use a registered state machine; stage_o SHALL equal the state encoding.
REQ-019 FETCH: imem_req_o=1 and imem_addr_o=pc_o; on imem_ack_i=1, ir_o<=imem_data_i and next state DECODE; with no ack, stay in FETCH with request held.
REQ-020 imem_req_o SHALL be 0 in every state other than FETCH; imem_ack_i outside FETCH SHALL be ignored.
REQ-021 DECODE SHALL last exactly 1 cycle, then EXECUTE.
REQ-022 EXECUTE SHALL last exactly 1 cycle; redirect_i and target_i SHALL be captured only in EXECUTE and ignored in all other states.
REQ-023 In EXECUTE with redirect_i=1 and target_i[1:0]!=0: next state HALT, fault_o<=1, pc unchanged, no retire.
REQ-024 MEM: stay while mem_busy_i=1; leave to WB on the first cycle mem_busy_i=0 (minimum 1 cycle).
REQ-025 WB SHALL last exactly 1 cycle, with wb_en_o=1 only in WB; next state FETCH.
REQ-026 On leaving WB, pc SHALL update to the captured target if a redirect was captured, else pc+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); the redirect flag SHALL clear.
REQ-027 retired_o SHALL increment by 1 on leaving WB and wrap modulo 2^32.
REQ-028 ir_o and pc_o SHALL remain stable from DECODE through WB.
REQ-029 HALT SHALL be absorbing until reset; all request/strobe outputs 0.
REQ-030 Minimum instruction latency SHALL be 5 cycles (ack in first FETCH cycle, no MEM stall).

Reset
REQ-031 reset=1 at a rising edge SHALL override all other inputs, including an ack or redirect in the same cycle.
REQ-032 After reset: state FETCH, pc_o=RESET_PC, ir_o=NOP_INSN, retired_o=0, fault_o=0, redirect flag=0, wb_en_o=0.
REQ-033 Reset asserted mid-operation in any state SHALL abandon the in-flight instruction with no retire and no wb_en_o pulse.
REQ-034 While reset is held, imem_req_o=0; the first cycle after deassertion SHALL show imem_req_o=1 with imem_addr_o=RESET_PC.

Verification
REQ-035 Reset release, ack on 1st FETCH cycle, data 32'h00500093, no stall -> stage_o 0,1,2,3,4,0; ir_o=32'h00500093; wb_en_o high 1 cycle; pc_o=4; retired_o=1.
REQ-036 Ack delayed 3 cycles, with a spurious ack during DECODE -> 4 FETCH cycles with req held; spurious ack ignored; ir_o unchanged.
REQ-037 redirect_i=1, target_i=32'h100 in EXECUTE, and redirect_i=1 again in MEM -> next fetch address 32'h100; the MEM redirect is ignored.
REQ-038 target_i=32'h102 with redirect in EXECUTE -> stage_o=7, fault_o=1, retired_o unchanged; remains so until reset.
REQ-039 pc_o=32'hFFFF_FFFC, mem_busy_i held for 2 cycles -> MEM lasts 3 cycles; next pc_o=0.
REQ-040 reset asserted during MEM, coincident with mem_busy_i deassert -> next stage_o=0, pc_o=RESET_PC, no wb_en_o, retired_o=0.
